cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
- Moore FSM plus instruction-field decoder that sequences the 16-bit datapath (regfile, A/B/C registers, shifter, ALU, status register) and the instruction/data memory interface.
- Takes the instruction-register contents and produces every datapath control strobe per cycle.
- Also produces PC, IR and address-register controls.
- Sits between the instruction register / memory and the datapath in the top-level CPU.

Parameters:
- none (16-bit instruction and 3-bit register index are fixed by the ISA).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state RST
- ir  in  16  instruction register: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm, [7:0] im8, [4:0] im5
- readnum  out  3  regfile read index
- writenum  out  3  regfile write index
- write  out  1  regfile write enable
- vsel  out  4  one-hot writeback select: 0001 C, 0010 sximm8, 0100 mdata, 1000 PC
- loada, loadb, loadc, loads  out  1 each  datapath register loads
- asel, bsel  out  1 each  ALU operand selects (asel=1 → A=0; bsel=1 → sximm5)
- shift  out  2  shifter op
- ALUop  out  2  ALU op
- sximm5  out  16  sign-extended ir[4:0]
- sximm8  out  16  sign-extended ir[7:0]
- load_ir, load_pc, reset_pc, addr_sel, load_addr  out  1 each  fetch/address control
- mem_cmd  out  2  00 none, 01 read, 10 write
- halted  out  1  high in HALT state

Behaviour:
- Fully Moore: every output is a function of state, plus ir fields where noted.
- Any output not listed for a state is 0, except readnum/writenum, which are 0 unless listed.
- Always-on decode: sximm5 = {{11{ir[4]}}, ir[4:0]}; sximm8 = {{8{ir[7]}}, ir[7:0]}.
- shift = ir[4:3], forced to 00 for opcodes 011 and 100.
- ALUop = ir[12:11] except where a state forces it.
- Reset: async entry to RST. In RST, reset_pc=1 and load_pc=1; all other outputs are 0.
  - First clock after reset deasserts → IF1.
  - Reset mid-instruction aborts it with no further write, load or mem_cmd.
- State sequence and outputs:
  - RST → IF1.
  - IF1: addr_sel=1, mem_cmd=01 → IF2.
  - IF2: addr_sel=1, mem_cmd=01, load_ir=1 → UPDATE_PC.
  - UPDATE_PC: load_pc=1 → DECODE.
  - DECODE: no outputs. Branch on {opcode, op}:
    - 110_10 → WRITE_IMM
    - 110_00 → GET_B
    - 101_00, 101_01, 101_10 → GET_A
    - 101_11 → GET_B
    - 011_00, 100_00 → GET_A
    - 111_xx → HALT
    - any other encoding → IF1 (NOP)
  - WRITE_IMM: writenum=Rn, vsel=0010, write=1 → IF1.
  - GET_A: readnum=Rn, loada=1 → ADDR if opcode 011/100, else GET_B.
  - GET_B: readnum=Rm, loadb=1 → EXEC.
  - EXEC: asel=1 for opcode 110 (MOV reg, ALUop=00 → 0+shifted Rm), else 0; bsel=0.
    - CMP (101_01): loads=1, loadc=0 → IF1.
    - All others: loadc=1, loads=0 → WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=0001, write=1 → IF1.
  - ADDR: asel=0, bsel=1, ALUop=00, loadc=1 → LOAD_ADDR.
  - LOAD_ADDR: load_addr=1, addr_sel=0 → MEM_RD1 (LDR) or STR_B (STR).
  - MEM_RD1: mem_cmd=01, addr_sel=0 → MEM_RD2.
  - MEM_RD2: mem_cmd=01, addr_sel=0, writenum=Rd, vsel=0100, write=1 → IF1.
  - STR_B: readnum=Rd, loadb=1 → STR_C.
  - STR_C: asel=1, bsel=0, ALUop=00, loadc=1 → MEM_WR.
  - MEM_WR: mem_cmd=10, addr_sel=0 → IF1.
  - HALT: halted=1, all else 0; absorbing until reset.
- Latency, cycles from entering IF1 to the next IF1:
  - MOV imm 5
  - MOV reg / MVN 7
  - CMP 7
  - ADD/AND 8
  - LDR 9
  - STR 10
- At most one of write / mem_cmd=10 is active in any cycle.
- vsel is always one-hot; it is 0000 whenever write=0.
- ir is sampled only in DECODE and later states; ir changes during IF1/IF2 have no effect on outputs other than the decode fields (sximm5, sximm8, shift, ALUop).

Test Plan:
- Reset held 2 cycles, released → RST outputs reset_pc=1, load_pc=1; next edges give IF1 (mem_cmd=01, addr_sel=1), then IF2 (load_ir=1), then UPDATE_PC (load_pc=1).
- ir=16'hD107 (MOV R1,#7) → WRITE_IMM: writenum=1, vsel=0010, write=1, sximm8=16'h0007; back in IF1 5 cycles after the previous IF1.
- ir=16'hA2C9 (ADD R6,R2,R1,LSL#1) → GET_A readnum=2, GET_B readnum=1, EXEC shift=01 ALUop=00 loadc=1, WRITE_REG writenum=6; 8-cycle instruction.
- ir=16'hA900 (CMP R1,R0) → EXEC loads=1 and loadc=0, no WRITE_REG; 7 cycles.
- ir=16'h6260 (LDR R3,[R2,#0]) then ir=16'h827F (STR R3,[R2,#-1]):
  - LDR: ADDR bsel=1; MEM_RD2 vsel=0100, writenum=3.
  - STR: sximm5=16'hFFFF; STR_B readnum=3; MEM_WR mem_cmd=10 with no write.
- ir=16'hE000 → halted=1 and held indefinitely; reset asserted mid-HALT → immediate RST. Separately, reset asserted during EXEC → no WRITE_REG write occurs.

Source files
------------

// File: rtl/cpu_controller.sv
// Sequencing FSM and instruction-field decoder for the 16-bit CPU datapath and memory interface.
// Outputs are decoded from the registered state and the current ir fields, so they are valid in the same cycle as the state.
// There is no backpressure. Every state lasts exactly one clock, and reset aborts the instruction in flight.
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic        load_ir,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        addr_sel,
  output logic        load_addr,
  output logic [1:0]  mem_cmd,
  output logic        halted
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WRITE_IMM,
    S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG, S_ADDR, S_LOAD_ADDR,
    S_MEM_RD1, S_MEM_RD2, S_STR_B, S_STR_C, S_MEM_WR, S_HALT
  } state_t;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  state_t r_state;

  // Instruction fields
  logic [2:0] w_opcode;
  logic [1:0] w_op;
  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [2:0] w_rm;
  logic       w_is_mem;
  logic       w_is_cmp;
  logic [1:0] w_shift;

  assign w_opcode = ir[15:13];
  assign w_op     = ir[12:11];
  assign w_rn     = ir[10:8];
  assign w_rd     = ir[7:5];
  assign w_rm     = ir[2:0];
  assign w_is_mem = (w_opcode == 3'b011) || (w_opcode == 3'b100);
  assign w_is_cmp = ({w_opcode, w_op} == 5'b101_01);
  // Loads and stores use ir[4:3] as immediate bits, not as a shift code.
  assign w_shift  = w_is_mem ? 2'b00 : ir[4:3];

  // The immediate extenders are always active, independent of state.
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  // State register. Reset is asynchronous, so an instruction in flight is dropped immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RST;
    end else begin
      case (r_state)
        S_RST:       r_state <= S_IF1;
        S_IF1:       r_state <= S_IF2;
        S_IF2:       r_state <= S_UPDATE_PC;
        S_UPDATE_PC: r_state <= S_DECODE;
        S_DECODE: begin
          casez ({w_opcode, w_op})
            5'b110_10:                     r_state <= S_WRITE_IMM;
            5'b110_00:                     r_state <= S_GET_B;
            5'b101_00, 5'b101_01, 5'b101_10: r_state <= S_GET_A;
            5'b101_11:                     r_state <= S_GET_B;
            5'b011_00, 5'b100_00:          r_state <= S_GET_A;
            5'b111_??:                     r_state <= S_HALT;
            default:                       r_state <= S_IF1;
          endcase
        end
        S_WRITE_IMM: r_state <= S_IF1;
        S_GET_A:     r_state <= w_is_mem ? S_ADDR : S_GET_B;
        S_GET_B:     r_state <= S_EXEC;
        S_EXEC:      r_state <= w_is_cmp ? S_IF1 : S_WRITE_REG;
        S_WRITE_REG: r_state <= S_IF1;
        S_ADDR:      r_state <= S_LOAD_ADDR;
        S_LOAD_ADDR: r_state <= (w_opcode == 3'b011) ? S_MEM_RD1 : S_STR_B;
        S_MEM_RD1:   r_state <= S_MEM_RD2;
        S_MEM_RD2:   r_state <= S_IF1;
        S_STR_B:     r_state <= S_STR_C;
        S_STR_C:     r_state <= S_MEM_WR;
        S_MEM_WR:    r_state <= S_IF1;
        S_HALT:      r_state <= S_HALT;
        default:     r_state <= S_RST;
      endcase
    end
  end

  // Per-state control decode. Any strobe not named in a state stays low.
  always_comb begin
    readnum   = 3'd0;
    writenum  = 3'd0;
    write     = 1'b0;
    vsel      = 4'b0000;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    shift     = w_shift;
    ALUop     = w_op;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    case (r_state)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
        shift    = 2'b00;
        ALUop    = 2'b00;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
      end
      S_UPDATE_PC: load_pc = 1'b1;
      S_WRITE_IMM: begin
        writenum = w_rn;
        vsel     = 4'b0010;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        // A MOV register reuses the adder with A forced to zero.
        asel  = (w_opcode == 3'b110);
        loads = w_is_cmp;
        loadc = !w_is_cmp;
      end
      S_WRITE_REG: begin
        writenum = w_rd;
        vsel     = 4'b0001;
        write    = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        ALUop = 2'b00;
        loadc = 1'b1;
      end
      S_LOAD_ADDR: load_addr = 1'b1;
      S_MEM_RD1:   mem_cmd = MEM_READ;
      S_MEM_RD2: begin
        mem_cmd  = MEM_READ;
        writenum = w_rd;
        vsel     = 4'b0100;
        write    = 1'b1;
      end
      S_STR_B: begin
        readnum = w_rd;
        loadb   = 1'b1;
      end
      S_STR_C: begin
        asel  = 1'b1;
        ALUop = 2'b00;
        loadc = 1'b1;
      end
      S_MEM_WR: mem_cmd = MEM_WRITE;
      S_HALT: begin
        halted = 1'b1;
        shift  = 2'b00;
        ALUop  = 2'b00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller. Each issued instruction pushes its expected datapath events and its fetch-to-fetch latency.
// A negedge monitor pops the expectations and compares them against the strobes it observes.
// Random instructions are classified by an ISA-level model.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [3:0]  vsel;
  logic [1:0]  shift, ALUop, mem_cmd;
  logic [15:0] sximm5, sximm8;
  logic        load_ir, load_pc, reset_pc, addr_sel, load_addr, halted;

  cpu_controller dut (
    .clk(clk), .reset(reset), .ir(ir),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .sximm5(sximm5), .sximm8(sximm8),
    .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
    .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] kind;
    logic [2:0] idx;
    logic [3:0] vsel;
    logic [1:0] sh;
    logic [1:0] alu;
    logic       asel;
    logic       bsel;
  } ev_t;

  localparam logic [2:0] K_RDA = 3'd0, K_RDB = 3'd1, K_LDC = 3'd2, K_LDS = 3'd3,
                         K_LADDR = 3'd4, K_MRD = 3'd5, K_WR = 3'd6, K_MWR = 3'd7;

  ev_t exp_q[$];
  ev_t tmp_q[$];
  int  lat_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  last_if1 = -1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  function automatic ev_t mk(logic [2:0] k, logic [2:0] idx, logic [3:0] v,
                             logic [1:0] s, logic [1:0] a, logic as, logic bs);
    ev_t e;
    e.kind = k; e.idx = idx; e.vsel = v; e.sh = s; e.alu = a; e.asel = as; e.bsel = bs;
    return e;
  endfunction

  function automatic logic [15:0] sext(int v, int bits);
    int r;
    r = v;
    if (r >= (1 << (bits - 1))) r = r - (1 << bits);
    return 16'(r);
  endfunction

  function automatic void observe(ev_t o);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual=%h required=none", o);
    end else begin
      check("event", 32'(o), 32'(exp_q.pop_front()));
    end
  endfunction

  // ISA-level reference model. It describes what each instruction must do to the datapath, in the order it must happen.
  task automatic model(input logic [15:0] i, output int lat);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    opc = i[15:13]; op = i[12:11]; rn = i[10:8]; rd = i[7:5]; sh = i[4:3]; rm = i[2:0];
    tmp_q.delete();
    if (opc == 3'b110 && op == 2'b10) begin
      tmp_q.push_back(mk(K_WR, rn, 4'b0010, 2'b00, 2'b00, 1'b0, 1'b0));
      lat = 5;
    end else if (opc == 3'b110 && op == 2'b00) begin
      tmp_q.push_back(mk(K_RDB, rm, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
      tmp_q.push_back(mk(K_LDC, 3'd0, 4'b0000, sh, 2'b00, 1'b1, 1'b0));
      tmp_q.push_back(mk(K_WR, rd, 4'b0001, 2'b00, 2'b00, 1'b0, 1'b0));
      lat = 7;
    end else if (opc == 3'b101) begin
      if (op != 2'b11) tmp_q.push_back(mk(K_RDA, rn, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
      tmp_q.push_back(mk(K_RDB, rm, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
      if (op == 2'b01) begin
        tmp_q.push_back(mk(K_LDS, 3'd0, 4'b0000, sh, 2'b01, 1'b0, 1'b0));
        lat = 7;
      end else begin
        tmp_q.push_back(mk(K_LDC, 3'd0, 4'b0000, sh, op, 1'b0, 1'b0));
        tmp_q.push_back(mk(K_WR, rd, 4'b0001, 2'b00, 2'b00, 1'b0, 1'b0));
        lat = (op == 2'b11) ? 7 : 8;
      end
    end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
      tmp_q.push_back(mk(K_RDA, rn, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
      tmp_q.push_back(mk(K_LDC, 3'd0, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b1));
      tmp_q.push_back(mk(K_LADDR, 3'd0, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
      if (opc == 3'b011) begin
        tmp_q.push_back(mk(K_MRD, 3'd0, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
        tmp_q.push_back(mk(K_MRD, 3'd0, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
        tmp_q.push_back(mk(K_WR, rd, 4'b0100, 2'b00, 2'b00, 1'b0, 1'b0));
        lat = 9;
      end else begin
        tmp_q.push_back(mk(K_RDB, rd, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
        tmp_q.push_back(mk(K_LDC, 3'd0, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b0));
        tmp_q.push_back(mk(K_MWR, 3'd0, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
        lat = 10;
      end
    end else if (opc == 3'b111) begin
      lat = -1;
    end else begin
      lat = 4;
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(9))
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      2: r[15:11] = 5'b10100;
      3: r[15:11] = 5'b10101;
      4: r[15:11] = 5'b10110;
      5: r[15:11] = 5'b10111;
      6: r[15:11] = 5'b01100;
      7: r[15:11] = 5'b10000;
      8: r[15:13] = 3'($urandom_range(2));
      default: r[15:11] = 5'b11001;
    endcase
    return r;
  endfunction

  // Monitor: invariants every cycle, fetch-to-fetch latency, and the event scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      last_if1 = -1;
    end else begin
      check("sximm5", 32'(sximm5), 32'(sext(int'(ir[4:0]), 5)));
      check("sximm8", 32'(sximm8), 32'(sext(int'(ir[7:0]), 8)));
      check("write_with_memwr", 32'(write && (mem_cmd == 2'b10)), 32'd0);
      check("vsel_onehot", 32'(write ? ($countones(vsel) == 1) : (vsel == 4'b0000)), 32'd1);
      if (mem_cmd == 2'b01 && addr_sel && !load_ir) begin
        if (last_if1 >= 0) begin
          if (lat_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL latency actual=%0d required=none", cyc - last_if1);
          end else begin
            check("latency", 32'(cyc - last_if1), 32'(lat_q.pop_front()));
          end
        end
        last_if1 = cyc;
      end
      if (loada) observe(mk(K_RDA, readnum, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
      if (loadb) observe(mk(K_RDB, readnum, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
      if (loadc) observe(mk(K_LDC, 3'd0, 4'b0000, shift, ALUop, asel, bsel));
      if (loads) observe(mk(K_LDS, 3'd0, 4'b0000, shift, ALUop, asel, bsel));
      if (load_addr) observe(mk(K_LADDR, {2'b00, addr_sel}, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
      if (mem_cmd == 2'b01 && !addr_sel) observe(mk(K_MRD, 3'd0, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
      if (write) observe(mk(K_WR, writenum, vsel, 2'b00, 2'b00, 1'b0, 1'b0));
      if (mem_cmd == 2'b10) observe(mk(K_MWR, {2'b00, addr_sel}, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0));
    end
  end

  task automatic timeout(string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", nm);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Hold reset for two cycles, release it, then step through RST, IF1 and IF2. Returns at the IF2 sample.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_outputs", 32'({reset_pc, load_pc, mem_cmd, load_ir, write, halted, loadc}), 32'b1100_0000);
    @(negedge clk);
    check("if1_outputs", 32'({mem_cmd, addr_sel, load_ir}), 32'b0110);
    @(negedge clk);
    check("if2_outputs", 32'({mem_cmd, addr_sel, load_ir}), 32'b0111);
  endtask

  // Wait for the IF2 cycle. Scrambling ir during IF1 must not disturb execution.
  task automatic wait_fetch();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (load_ir) return;
      if (mem_cmd == 2'b01 && addr_sel && $urandom_range(1) == 1) begin
        #1 ir = 16'($urandom);
      end
    end
    timeout("fetch_wait");
  endtask

  // Present a new instruction on the IR edge and record its expectations.
  // With abort set, the final register write and the latency are left out.
  task automatic issue(input logic [15:0] instr, input bit abort);
    int lat;
    @(posedge clk);
    #1 ir = instr;
    model(instr, lat);
    if (abort && tmp_q.size() > 0) void'(tmp_q.pop_back());
    foreach (tmp_q[k]) exp_q.push_back(tmp_q[k]);
    if (!abort && lat >= 0) lat_q.push_back(lat);
    @(negedge clk);
    check("update_pc", 32'({load_pc, reset_pc, load_ir}), 32'b100);
  endtask

  initial begin
    ir = 16'h0000;
    reset = 1'b1;
    do_reset();

    // Directed program
    issue(16'hD107, 1'b0);
    check("mov_imm_sximm8", 32'(sximm8), 32'h0007);
    wait_fetch(); issue(16'hA2C9, 1'b0);
    wait_fetch(); issue(16'hA900, 1'b0);
    wait_fetch(); issue(16'h6260, 1'b0);
    wait_fetch(); issue(16'h827F, 1'b0);
    check("str_sximm5", 32'(sximm5), 32'hFFFF);

    // Random program
    for (int n = 0; n < 150; n++) begin
      wait_fetch();
      issue(rand_instr(), 1'b0);
    end

    // Reset during EXEC of an ADD. The register write must never occur.
    wait_fetch();
    issue(16'hA2C9, 1'b1);
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        if (loadc) seen = 1'b1;
      end
      if (!seen) timeout("exec_wait");
    end
    #2 reset = 1'b1;
    #1 check("abort_rst", 32'({reset_pc, load_pc, write, loadc}), 32'b1100);
    do_reset();

    issue(rand_instr(), 1'b0);
    for (int n = 0; n < 20; n++) begin
      wait_fetch();
      issue(rand_instr(), 1'b0);
    end

    // HALT is absorbing until reset arrives.
    wait_fetch();
    issue(16'hE000, 1'b0);
    @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("halt_hold", 32'({halted, write, mem_cmd, load_pc, load_ir, loada, loadb, loadc}),
            32'b1_0_00_0_0_0_0_0);
    end
    #2 reset = 1'b1;
    #1 check("halt_reset", 32'({reset_pc, load_pc, halted}), 32'b110);
    repeat (2) @(negedge clk);
    check("events_drained", 32'(exp_q.size()), 32'd0);
    check("latency_drained", 32'(lat_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
